// File: rtl/cpu_pkg.sv
// Shared CPU constants and types: reset fetch address, NOP encoding,
// fetch FSM states and the sequential-PC helper.
package cpu_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  typedef enum logic {
    RUN   = 1'b0,
    DRAIN = 1'b1
  } fetch_state_t;

  // Sequential successor; 32-bit arithmetic wraps FFFF_FFFC to 0.
  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: clear inserts a bubble, enable loads a new
// instruction with its PC+4, otherwise the contents hold.
module if_id_reg
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr,
  input  logic [31:0] instr_next,
  input  logic [31:0] pc4_next,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  logic [31:0] instr_reg;
  logic [31:0] pc4_reg;
  logic        valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_reg <= NOP_INSTR;
      pc4_reg   <= 32'd0;
      valid_reg <= 1'b0;
    end else if (clr) begin
      instr_reg <= NOP_INSTR;
      valid_reg <= 1'b0;
    end else if (en) begin
      instr_reg <= instr_next;
      pc4_reg   <= pc4_next;
      valid_reg <= 1'b1;
    end
  end

  assign instr = instr_reg;
  assign pc4   = pc4_reg;
  assign valid = valid_reg;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the instruction-memory request, absorbs
// load-use stalls with a one-entry hold buffer and handles ID redirects.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        branchAvail,
  input  logic [31:0] branchTarget,
  input  logic        jump,
  input  logic [31:0] jumpTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  fetch_state_t state_reg;
  logic [31:0]  pc_reg;
  logic [31:0]  addr_reg;
  logic         req_reg;
  logic [31:0]  pend_target_reg;
  logic [31:0]  hold_instr_reg;
  logic [31:0]  hold_pc4_reg;
  logic         hold_valid_reg;

  logic         completion;
  logic         redirect;
  logic [31:0]  target;
  logic [31:0]  pc4;

  logic         id_en;
  logic         id_clr;
  logic [31:0]  id_instr_next;
  logic [31:0]  id_pc4_next;

  assign imem_req   = req_reg;
  assign imem_addr  = addr_reg;
  assign completion = req_reg && imem_ready;
  assign redirect   = (state_reg == RUN) && !stall && (jump || branchAvail);
  assign target     = jump ? jumpTarget : branchTarget;
  assign pc4        = next_seq_pc(pc_reg);

  // IF/ID load/clear selection; a stalled ID stage simply holds.
  always_comb begin
    id_en         = 1'b0;
    id_clr        = 1'b0;
    id_instr_next = imem_rdata;
    id_pc4_next   = pc4;
    if (state_reg == DRAIN || redirect) begin
      id_clr = 1'b1;
    end else if (!stall) begin
      if (hold_valid_reg) begin
        id_en         = 1'b1;
        id_instr_next = hold_instr_reg;
        id_pc4_next   = hold_pc4_reg;
      end else if (completion) begin
        id_en = 1'b1;
      end else begin
        id_clr = 1'b1;
      end
    end
  end

  // Request/address are registered from the next state so they stay put
  // for the whole life of an outstanding fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= RUN;
      pc_reg          <= RESET_PC;
      addr_reg        <= RESET_PC;
      req_reg         <= 1'b0;
      pend_target_reg <= 32'd0;
      hold_instr_reg  <= NOP_INSTR;
      hold_pc4_reg    <= 32'd0;
      hold_valid_reg  <= 1'b0;
    end else begin
      case (state_reg)
        RUN: begin
          if (redirect) begin
            hold_valid_reg <= 1'b0;
            if (completion || !req_reg) begin
              pc_reg   <= target;
              addr_reg <= target;
              req_reg  <= 1'b1;
            end else begin
              pend_target_reg <= target;
              state_reg       <= DRAIN;
            end
          end else if (hold_valid_reg && !stall) begin
            hold_valid_reg <= 1'b0;
            req_reg        <= 1'b1;
          end else if (completion) begin
            pc_reg   <= pc4;
            addr_reg <= pc4;
            if (stall) begin
              hold_instr_reg <= imem_rdata;
              hold_pc4_reg   <= pc4;
              hold_valid_reg <= 1'b1;
              req_reg        <= 1'b0;
            end
          end else begin
            req_reg <= !hold_valid_reg;
          end
        end
        DRAIN: begin
          // The stale fetch must finish before the redirect target goes out.
          if (completion) begin
            pc_reg    <= pend_target_reg;
            addr_reg  <= pend_target_reg;
            state_reg <= RUN;
          end
        end
        default: state_reg <= RUN;
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (id_en),
    .clr        (id_clr),
    .instr_next (id_instr_next),
    .pc4_next   (id_pc4_next),
    .instr      (if_id_instr),
    .pc4        (if_id_pc4),
    .valid      (if_id_valid)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random
// stall/ready/redirect traffic checked against a program-order model.
module tb_fetch_unit;

  localparam logic [31:0] START_PC = 32'h0000_3000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        branchAvail;
  logic [31:0] branchTarget;
  logic        jump;
  logic [31:0] jumpTarget;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;

  int checks   = 0;
  int errors   = 0;
  int consumed = 0;

  // Model: address of the next instruction ID should see in program order.
  logic [31:0] exp_pc;
  logic        pend_prev;
  logic [31:0] pend_addr;

  fetch_unit #(.RESET_PC(START_PC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .branchAvail  (branchAvail),
    .branchTarget (branchTarget),
    .jump         (jump),
    .jumpTarget   (jumpTarget),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .if_id_instr  (if_id_instr),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h2408_0001;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle, entered and left on a falling edge.
  task automatic drive_cycle(input logic s, input logic br, input logic [31:0] bt,
                             input logic jp, input logic [31:0] jt, input logic rdy);
    if (pend_prev) begin
      check("req_held", 32'(imem_req), 32'd1);
      check("addr_held", imem_addr, pend_addr);
    end
    if (if_id_valid) begin
      check("id_instr", if_id_instr, mem_word(exp_pc));
      check("id_pc4", if_id_pc4, exp_pc + 32'd4);
    end
    stall        = s;
    branchAvail  = br;
    branchTarget = bt;
    jump         = jp;
    jumpTarget   = jt;
    imem_ready   = rdy;
    imem_rdata   = rdy ? mem_word(imem_addr) : $urandom;
    if (!s && if_id_valid) begin
      consumed++;
      if (jp)      exp_pc = jt;
      else if (br) exp_pc = bt;
      else         exp_pc = exp_pc + 32'd4;
    end
    pend_prev = imem_req && !rdy;
    pend_addr = imem_addr;
    @(negedge clk);
  endtask

  task automatic go(input logic rdy);
    drive_cycle(1'b0, 1'b0, 32'd0, 1'b0, 32'd0, rdy);
  endtask

  task automatic run_until_valid();
    for (int i = 0; i < 10 && !if_id_valid; i++) go(1'b1);
    check("id_valid_wait", 32'(if_id_valid), 32'd1);
  endtask

  task automatic apply_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(if_id_valid), 32'd0);
    check("rst_instr", if_id_instr, 32'd0);
    check("rst_pc4", if_id_pc4, 32'd0);
    stall = 1'b0; jump = 1'b0; branchAvail = 1'b0; imem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    exp_pc    = START_PC;
    pend_prev = 1'b0;
    for (int i = 0; i < 4 && !imem_req; i++) go(1'b1);
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, START_PC);
  endtask

  initial begin
    logic        s, br, jp, rdy;
    logic [31:0] tgt;
    rst_n = 1'b1; stall = 1'b0; branchAvail = 1'b0; jump = 1'b0;
    branchTarget = 32'd0; jumpTarget = 32'd0; imem_ready = 1'b0; imem_rdata = 32'd0;
    exp_pc = START_PC; pend_prev = 1'b0; pend_addr = 32'd0;
    @(negedge clk);

    apply_reset();
    $display("phase: sequential fetch after reset");
    go(1'b1);
    check("seq_addr1", imem_addr, 32'h3004);
    check("seq_pc4", if_id_pc4, 32'h3004);
    check("seq_valid", 32'(if_id_valid), 32'd1);
    go(1'b1);
    check("seq_addr2", imem_addr, 32'h3008);
    go(1'b1); go(1'b1);
    check("drain_setup_addr", imem_addr, 32'h3010);

    $display("phase: redirect during slow fetch");
    drive_cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'h3080, 1'b0);
    for (int i = 0; i < 2; i++) begin
      check("drain_req", 32'(imem_req), 32'd1);
      check("drain_addr", imem_addr, 32'h3010);
      check("drain_valid", 32'(if_id_valid), 32'd0);
      go(1'b0);
    end
    check("drain_addr_last", imem_addr, 32'h3010);
    go(1'b1);
    check("drain_target", imem_addr, 32'h3080);
    check("drain_bubble", 32'(if_id_valid), 32'd0);
    go(1'b1);
    check("drain_resume_pc4", if_id_pc4, 32'h3084);

    $display("phase: reset in the middle of a drain");
    run_until_valid();
    drive_cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'h3200, 1'b0);
    go(1'b0);
    check("rst_drain_req", 32'(imem_req), 32'd1);
    apply_reset();

    $display("phase: load-use stall");
    go(1'b1); go(1'b1);
    run_until_valid();
    drive_cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    check("stall_req_low", 32'(imem_req), 32'd0);
    drive_cycle(1'b1, 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    check("unstall_req_low", 32'(imem_req), 32'd0);
    go(1'b1);
    check("refill_req", 32'(imem_req), 32'd1);
    go(1'b1); go(1'b1);

    $display("phase: branch, jump priority, wrap, unaligned target");
    run_until_valid();
    drive_cycle(1'b0, 1'b1, 32'h3040, 1'b0, 32'd0, 1'b1);
    check("br_addr", imem_addr, 32'h3040);
    check("br_bubble", 32'(if_id_valid), 32'd0);
    go(1'b1);
    check("br_valid", 32'(if_id_valid), 32'd1);
    check("br_pc4", if_id_pc4, 32'h3044);
    drive_cycle(1'b0, 1'b1, 32'h3040, 1'b1, 32'h3100, 1'b1);
    check("jmp_prio_addr", imem_addr, 32'h3100);
    run_until_valid();
    drive_cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC, 1'b1);
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    go(1'b1);
    check("wrap_next_addr", imem_addr, 32'd0);
    check("wrap_pc4", if_id_pc4, 32'd0);
    run_until_valid();
    drive_cycle(1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_3102, 1'b1);
    check("unaligned_addr", imem_addr, 32'h0000_3102);
    go(1'b1); go(1'b1);

    $display("phase: random traffic");
    consumed = 0;
    for (int n = 0; n < 1500; n++) begin
      s   = ($urandom % 4) == 0;
      rdy = ($urandom % 3) != 0;
      br  = 1'b0;
      jp  = 1'b0;
      tgt = START_PC + ($urandom_range(0, 63) << 2);
      if (($urandom % 5) == 0) tgt[1:0] = 2'($urandom);
      if (!s && if_id_valid && ($urandom % 8) == 0) begin
        br = $urandom % 2;
        jp = !br || ($urandom % 2);
      end
      drive_cycle(s, br, tgt + 32'h40, jp, tgt, rdy);
    end
    check("progress", 32'(consumed > 200), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
